// File: rtl/gate_bist_pkg.sv
// Shared types for the gate self-test engine: reference-op encodings and FSM states.
package gate_bist_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND  = 2'd0;
    localparam op_t OP_OR   = 2'd1;
    localparam op_t OP_XOR  = 2'd2;
    localparam op_t OP_NAND = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/gate_bist_ref.sv
// Reference gate: expected output bit for a given input vector and operation.
module gate_bist_ref
    import gate_bist_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] vec,
    input  op_t          op,
    output logic         exp_y
);

    always_comb begin
        exp_y = 1'b0;
        case (op)
            OP_AND:  exp_y = &vec;
            OP_OR:   exp_y = |vec;
            OP_XOR:  exp_y = ^vec;
            OP_NAND: exp_y = ~&vec;
            default: exp_y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_bist.sv
// Exhaustive self-test of an N-input combinational gate against a selectable reference,
// reporting mismatch count, first failing vector and a pass/fail verdict.
//
// state | meaning
// IDLE  | waiting for start; previous verdict stays visible
// DRIVE | present current vector on dut_in
// WAIT  | settle countdown before sampling dut_y
// CHECK | compare dut_y against reference, advance or finish
// DONE  | publish verdict, drop busy, return to IDLE
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int N      = 2,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  op_t              op,
    output logic [N-1:0]     dut_in,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [N-1:0]     first_fail_vec,
    output logic             first_fail_valid
);

    // One extra vec bit keeps the terminal compare from wrapping to zero.
    localparam logic [N:0]       VEC_LAST  = (N+1)'((1 << N) - 1);
    localparam logic [N:0]       VEC_ONE   = (N+1)'(1);
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
    localparam logic [3:0]       SETTLE_LD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t     state;
    logic [N:0] vec;
    logic [3:0] settle_cnt;
    op_t        op_q;
    logic       exp_y;

    gate_bist_ref #(.N(N)) u_ref (
        .vec   (vec[N-1:0]),
        .op    (op_q),
        .exp_y (exp_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            vec              <= '0;
            settle_cnt       <= '0;
            op_q             <= OP_AND;
            dut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec              <= '0;
                        err_cnt          <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        busy             <= 1'b1;
                        op_q             <= op;
                        state            <= DRIVE;
                    end
                end
                DRIVE: begin
                    dut_in <= vec[N-1:0];
                    if (SETTLE > 0) begin
                        settle_cnt <= SETTLE_LD;
                        state      <= WAIT;
                    end else begin
                        state <= CHECK;
                    end
                end
                WAIT: begin
                    if (settle_cnt == 4'd0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    // X/Z on dut_y must count as a failure, hence the 4-state compare.
                    if (dut_y !== exp_y) begin
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + ERR_ONE;
                        end
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec[N-1:0];
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (vec == VEC_LAST) begin
                        state <= DONE;
                    end else begin
                        vec   <= vec + VEC_ONE;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    pass  <= (err_cnt == '0);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: two configurations checked every cycle against a time-based model,
// plus directed scenarios with hand-computed verdicts and latencies.
module tb_gate_bist;
    import gate_bist_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance 0: N=2, SETTLE=2, ERR_W=8
    logic       start0 = 1'b0;
    op_t        op0 = OP_AND;
    int         mode0 = 0;
    logic [1:0] dut_in0;
    logic       dut_y0, and0;
    logic       busy0, done0, pass0, ffval0;
    logic [7:0] err0;
    logic [1:0] ffv0;

    // instance 1: N=4, SETTLE=0, ERR_W=2
    logic       start1 = 1'b0;
    op_t        op1 = OP_AND;
    int         mode1 = 0;
    logic [3:0] dut_in1;
    logic       dut_y1;
    logic       busy1, done1, pass1, ffval1;
    logic [1:0] err1;
    logic [3:0] ffv1;

    // gate under test: mode 0 = correct AND, 1 = stuck-at-0, 2 = inverted AND
    gate_bist_ref #(.N(2)) u_gut0 (.vec(dut_in0), .op(OP_AND), .exp_y(and0));
    assign dut_y0 = (mode0 == 1) ? 1'b0 : (mode0 == 2) ? ~and0 : and0;
    assign dut_y1 = (mode1 == 1) ? 1'b0 : (mode1 == 2) ? ~(&dut_in1) : (&dut_in1);

    gate_bist #(.N(2), .SETTLE(2), .ERR_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .op(op0), .dut_in(dut_in0), .dut_y(dut_y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffval0)
    );

    gate_bist #(.N(4), .SETTLE(0), .ERR_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1), .dut_in(dut_in1), .dut_y(dut_y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffval1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cn[2]   = '{2, 4};
    int cs[2]   = '{2, 0};
    int cmax[2] = '{255, 3};

    int m_busy[2], m_done[2], m_pass[2], m_err[2], m_ffv[2], m_ffval[2];
    int m_din[2], m_t[2], m_op[2];

    function automatic int ref_of(input int o, input int v, input int n);
        int all1;
        all1 = (1 << n) - 1;
        case (o)
            0: return (v == all1) ? 1 : 0;
            1: return (v != 0) ? 1 : 0;
            2: return $countones(v) % 2;
            default: return (v != all1) ? 1 : 0;
        endcase
    endfunction

    function automatic int gut_of(input int md, input int v, input int n);
        int a;
        a = (v == (1 << n) - 1) ? 1 : 0;
        if (md == 1) return 0;
        if (md == 2) return 1 - a;
        return a;
    endfunction

    task automatic model_reset(input int i);
        m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_err[i] = 0;
        m_ffv[i] = 0; m_ffval[i] = 0; m_din[i] = 0; m_t[i] = 0; m_op[i] = 0;
    endtask

    // Vector v is driven (S+2)*v+1 edges after the start edge and judged (S+2)*(v+1) edges after.
    task automatic model_step(input int i, input logic st, input int o, input int md);
        int per, fin, vi;
        per = cs[i] + 2;
        fin = (1 << cn[i]) * per + 1;
        if (m_busy[i] == 0) begin
            if (st) begin
                m_busy[i] = 1; m_t[i] = 0; m_done[i] = 0; m_pass[i] = 0;
                m_err[i] = 0; m_ffval[i] = 0; m_ffv[i] = 0; m_op[i] = o;
            end
        end else begin
            m_t[i]++;
            if (m_t[i] == fin) begin
                m_busy[i] = 0;
                m_done[i] = 1;
                m_pass[i] = (m_err[i] == 0) ? 1 : 0;
            end else begin
                if ((m_t[i] - 1) % per == 0) m_din[i] = (m_t[i] - 1) / per;
                if (m_t[i] % per == 0) begin
                    vi = m_t[i] / per - 1;
                    if (gut_of(md, vi, cn[i]) != ref_of(m_op[i], vi, cn[i])) begin
                        if (m_err[i] < cmax[i]) m_err[i]++;
                        if (m_ffval[i] == 0) begin
                            m_ffval[i] = 1;
                            m_ffv[i] = vi;
                        end
                    end
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, start0, int'(op0), mode0);
            model_step(1, start1, int'(op1), mode1);
        end
    end

    always @(negedge clk) begin
        chk("busy0",   int'(busy0),   m_busy[0]);
        chk("done0",   int'(done0),   m_done[0]);
        chk("pass0",   int'(pass0),   m_pass[0]);
        chk("err0",    int'(err0),    m_err[0]);
        chk("ffval0",  int'(ffval0),  m_ffval[0]);
        chk("ffv0",    int'(ffv0),    m_ffv[0]);
        chk("dut_in0", int'(dut_in0), m_din[0]);
        chk("busy1",   int'(busy1),   m_busy[1]);
        chk("done1",   int'(done1),   m_done[1]);
        chk("pass1",   int'(pass1),   m_pass[1]);
        chk("err1",    int'(err1),    m_err[1]);
        chk("ffval1",  int'(ffval1),  m_ffval[1]);
        chk("ffv1",    int'(ffv1),    m_ffv[1]);
        chk("dut_in1", int'(dut_in1), m_din[1]);
    end

    // ---------------- directed stimulus ----------------
    // Starts a run and returns edges from the start edge until done is seen high.
    task automatic do_run(input int inst, input op_t o, input int md, input int pulse_at,
                          output int lat);
        bit seen;
        seen = 1'b0;
        if (inst == 0) begin op0 = o; mode0 = md; start0 = 1'b1; end
        else           begin op1 = o; mode1 = md; start1 = 1'b1; end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        chk("start_busy", int'(inst == 0 ? busy0 : busy1), 1);
        chk("start_done_clr", int'(inst == 0 ? done0 : done1), 0);
        lat = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (c == pulse_at) begin
                if (inst == 0) begin start0 = 1'b1; op0 = op_t'(o ^ 2'b11); end
                else           begin start1 = 1'b1; op1 = op_t'(o ^ 2'b11); end
            end
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            lat++;
            if ((inst == 0 ? done0 : done1) === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            lat = -1;
        end
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_busy",   int'(busy0),   0);
        chk("rst_done",   int'(done0),   0);
        chk("rst_pass",   int'(pass0),   0);
        chk("rst_err",    int'(err0),    0);
        chk("rst_ffval",  int'(ffval0),  0);
        chk("rst_ffv",    int'(ffv0),    0);
        chk("rst_dut_in", int'(dut_in0), 0);

        // correct AND, op AND
        do_run(0, OP_AND, 0, -1, lat);
        chk("and_ok_lat", lat, 17);
        chk("and_ok_pass", int'(pass0), 1);
        chk("and_ok_err", int'(err0), 0);
        chk("and_ok_ffval", int'(ffval0), 0);

        // stuck-at-0, started while done is high
        do_run(0, OP_AND, 1, -1, lat);
        chk("stuck_lat", lat, 17);
        chk("stuck_err", int'(err0), 1);
        chk("stuck_ffv", int'(ffv0), 3);
        chk("stuck_pass", int'(pass0), 0);

        // correct AND judged against OR
        do_run(0, OP_OR, 0, -1, lat);
        chk("or_err", int'(err0), 2);
        chk("or_ffv", int'(ffv0), 1);
        chk("or_pass", int'(pass0), 0);

        // N=4, SETTLE=0, inverted AND: saturating counter
        do_run(1, OP_AND, 2, -1, lat);
        chk("inv_lat", lat, 33);
        chk("inv_err_sat", int'(err1), 3);
        chk("inv_ffv", int'(ffv1), 0);
        chk("inv_ffval", int'(ffval1), 1);
        chk("inv_pass", int'(pass1), 0);

        // abort with reset at cycle 6 of a failing run
        op0 = OP_AND; mode0 = 2; start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy0), 0);
        chk("abort_done", int'(done0), 0);
        chk("abort_err", int'(err0), 0);
        chk("abort_ffval", int'(ffval0), 0);
        chk("abort_dut_in", int'(dut_in0), 0);
        chk("abort_done1", int'(done1), 0);
        @(posedge clk); #1 rst = 1'b0;
        do_run(0, OP_AND, 0, -1, lat);
        chk("restart_lat", lat, 17);
        chk("restart_pass", int'(pass0), 1);

        // start pulse and op change mid-run are ignored; XOR vs AND fails 01,10,11
        do_run(0, OP_XOR, 0, 5, lat);
        chk("busy_start_lat", lat, 17);
        chk("xor_err", int'(err0), 3);
        chk("xor_ffv", int'(ffv0), 1);

        // inverted AND is a correct NAND
        do_run(0, OP_NAND, 2, -1, lat);
        chk("nand_pass", int'(pass0), 1);
        chk("nand_err", int'(err0), 0);

        repeat (3) @(posedge clk);
        #1;
        chk("hold_dut_in", int'(dut_in0), 3);
        chk("hold_done", int'(done0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
